ssd_scan_ctrl: RTL

SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

---
 rtl/ssd_scan_ctrl_pkg.sv | 37 +++
 rtl/ssd_scan_ctrl_hex_to_ssd.sv | 14 +
 rtl/ssd_scan_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/ssd_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scan controller: segment patterns,
// blanking value, FSM encoding and digit count.
package ssd_pkg;

  localparam int NUM_DIGITS = 8;
  localparam logic [7:0] BLANK_PATTERN = 8'hFF;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } ssd_state_e;

  // Segment order abcdefg, active-low
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

endpackage

// File: rtl/ssd_scan_ctrl_hex_to_ssd.sv
// Combinational hex digit to active-low abcdefg segment decode.
module hex_to_ssd
  import ssd_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Table lookup covers all 16 codes
  always_comb begin
    seg = SEG_TABLE[hex];
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scan controller with per-slot anti-ghosting
// blanking, a write-anywhere digit buffer and a frame-complete pulse.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int DIGIT_CYCLES = 262144,
  parameter int BLANK_CYCLES = 4096
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       scan_en,
  input  logic [7:0] digit_en,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  output logic [7:0] An,
  output logic [7:0] Cathodes,
  output logic       frame_done,
  output logic [2:0] cur_digit
);

  localparam int CW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(DIGIT_CYCLES - 1);
  localparam logic [2:0]    LAST_DIGIT = 3'(NUM_DIGITS - 1);

  ssd_state_e      state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [2:0]      digit_r, digit_s;
  logic            en_r, en_s;
  logic [4:0]      buf_r [NUM_DIGITS];
  logic [4:0]      entry_s;
  logic [6:0]      seg_s;
  logic [7:0]      an_r, an_s;
  logic [7:0]      cath_r, cath_s;
  logic            fd_r, fd_s;

  assign entry_s = buf_r[digit_s];

  hex_to_ssd u_hex_to_ssd (
    .hex (entry_s[3:0]),
    .seg (seg_s)
  );

  // Next slot position: scan_en low forces OFF from any state
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    digit_s = digit_r;
    en_s    = en_r;
    if (!scan_en) begin
      state_s = ST_OFF;
      cnt_s   = '0;
      digit_s = 3'd0;
      en_s    = 1'b0;
    end else begin
      case (state_r)
        ST_OFF: begin
          state_s = ST_BLANK;
          cnt_s   = '0;
          digit_s = 3'd0;
        end
        ST_BLANK: begin
          cnt_s = cnt_r + CW'(1);
          if (cnt_r == BLANK_LAST) begin
            state_s = ST_DRIVE;
            en_s    = digit_en[digit_r];
          end else begin
            state_s = ST_BLANK;
          end
        end
        ST_DRIVE: begin
          if (cnt_r == SLOT_LAST) begin
            state_s = ST_BLANK;
            cnt_s   = '0;
            digit_s = digit_r + 3'd1;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end
        default: begin
          state_s = ST_OFF;
          cnt_s   = '0;
          digit_s = 3'd0;
          en_s    = 1'b0;
        end
      endcase
    end
  end

  // Outputs are computed from the next position so they line up with the state
  always_comb begin
    an_s   = BLANK_PATTERN;
    cath_s = BLANK_PATTERN;
    if (state_s == ST_DRIVE) begin
      cath_s = {seg_s, ~entry_s[4]};
      if (en_s) begin
        an_s = ~(8'h01 << digit_s);
      end else begin
        an_s = BLANK_PATTERN;
      end
    end else begin
      an_s   = BLANK_PATTERN;
      cath_s = BLANK_PATTERN;
    end
    fd_s = (state_s == ST_DRIVE) && (cnt_s == SLOT_LAST) && (digit_s == LAST_DIGIT);
  end

  // FSM, counter and registered display outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= ST_OFF;
      cnt_r   <= '0;
      digit_r <= 3'd0;
      en_r    <= 1'b0;
      an_r    <= BLANK_PATTERN;
      cath_r  <= BLANK_PATTERN;
      fd_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      digit_r <= digit_s;
      en_r    <= en_s;
      an_r    <= an_s;
      cath_r  <= cath_s;
      fd_r    <= fd_s;
    end
  end

  // Digit buffer; writes accepted in every scan state
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        buf_r[i] <= 5'b0_0000;
      end
    end else if (wr_en) begin
      buf_r[wr_addr] <= wr_data;
    end
  end

  assign An         = an_r;
  assign Cathodes   = cath_r;
  assign frame_done = fd_r;
  assign cur_digit  = digit_r;

endmodule
